pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter PC_STEP, default 4, byte increment per fetch; power of two, at least 1.
REQ-004 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-005 SHALL have parameter HALT_WORD, default all-ones, instruction encoding that halts fetch.
REQ-006 SHALL have parameter CNT_W, default 16, fetch-counter width.
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port pc_reset_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port pc_enable, input, 1, level, run mode request.
REQ-010 SHALL have port step_req, input, 1, single-step request, sampled in IDLE.
REQ-011 SHALL have port stall, input, 1, hold PC and IF/ID.
REQ-012 SHALL have port redirect_valid, input, 1, branch/jump/debug PC load.
REQ-013 SHALL have port redirect_addr, input, ADDR_W, redirect target.
REQ-014 SHALL have port imem_addr, output, ADDR_W, equals current PC, combinational from the PC register.
REQ-015 SHALL have port imem_rdata, input, INSTR_W, combinational instruction memory data for imem_addr.
REQ-016 SHALL have port if_pc_out, output, ADDR_W, PC of the latched instruction.
REQ-017 SHALL have port if_pc_plus_out, output, ADDR_W, if_pc_out+PC_STEP.
REQ-018 SHALL have port if_instr_out, output, INSTR_W, latched instruction.
REQ-019 SHALL have port if_valid_out, output, 1, IF/ID holds a valid instruction.
REQ-020 SHALL have port state_out, output, 2, IDLE=00, RUN=01, STEP=10, HALT=11.
REQ-021 SHALL have port halted, output, 1, high when state is HALT.
REQ-022 SHALL have port fetch_count, output, CNT_W, number of completed fetches.

Function
REQ-023 SHALL define fetch as: state RUN or STEP, no redirect, no stall; on fetch the IF/ID register SHALL latch {PC, PC+PC_STEP, imem_rdata, valid=1}.
REQ-024 SHALL use per-cycle priority redirect > stall > fetch > idle in every state except HALT.
REQ-025 On redirect, SHALL load PC with redirect_addr with its low log2(PC_STEP) bits cleared, clear if_valid_out and if_instr_out, hold if_pc_out, not count a fetch, and leave state unchanged.
REQ-026 On stall without redirect, SHALL hold PC, all IF/ID fields, state and fetch_count.
REQ-027 On a fetch of a non-HALT_WORD instruction, SHALL advance PC by PC_STEP modulo 2^ADDR_W, so that the PC wraps from the maximum aligned value to 0.
REQ-028 On a fetch of HALT_WORD, SHALL latch it with valid=1, hold PC at the halt address, and enter HALT next cycle.
REQ-029 In any cycle with no fetch and no stall, SHALL clear if_valid_out and hold the other IF/ID fields.
REQ-030 Fetch latency SHALL be 1 cycle, from PC presented on imem_addr to IF/ID outputs.
REQ-031 FSM transitions from IDLE SHALL be: pc_enable=1 to RUN; otherwise step_req=1 to STEP; otherwise stay in IDLE.
REQ-032 FSM transitions from RUN SHALL be: HALT_WORD fetched to HALT; otherwise pc_enable=0 to IDLE.
REQ-033 FSM transitions from STEP SHALL be: a fetch occurs to IDLE, or to HALT if the fetched word is HALT_WORD; on stall or redirect, stay in STEP.
REQ-034 In HALT, SHALL ignore pc_enable, step_req, stall and redirect, hold PC, and keep if_valid_out at 0 from the cycle after entry; only reset SHALL exit HALT.
REQ-035 fetch_count SHALL increment by 1 per fetch and saturate at 2^CNT_W-1.

Reset
REQ-036 While pc_reset_n=0, SHALL immediately and asynchronously force: PC=RESET_VECTOR, state IDLE, halted=0, if_valid_out=0, if_pc_out=0, if_pc_plus_out=0, if_instr_out=0, fetch_count=0.
REQ-037 The first fetch SHALL occur no earlier than the second rising clk edge after pc_reset_n deasserts (one edge to enter RUN/STEP).
REQ-038 Reset asserted mid-run SHALL discard in-flight state, with no partial fetch retained.

Verification (ADDR_W=32, PC_STEP=4, RESET_VECTOR=0, mem[word i]=i+1)
REQ-039 Run test: reset, then pc_enable=1 for 6 cycles -> if_pc_out 0,4,8,12,16; if_instr_out 1..5; fetch_count=5.
REQ-040 Stall test: stall=1 for 2 cycles while if_pc_out=8 -> IF/ID and imem_addr=12 held; resumes with if_pc_out=12.
REQ-041 Redirect test: redirect_valid=1, redirect_addr=0x103, stall=1 in the same cycle -> PC=0x100, if_valid_out=0 next cycle; next fetch gives if_pc_out=0x100.
REQ-042 Step test: in IDLE with PC=0x20, pulse step_req -> exactly one fetch (if_pc_out=0x20, valid one cycle), state back to IDLE, PC=0x24.
REQ-043 Halt test: mem[3]=HALT_WORD -> HALT_WORD latched with if_pc_out=0x0C, halted=1, imem_addr stays 0x0C; pc_enable and redirect ignored.
REQ-044 Wrap/reset test: redirect to 0xFFFFFFFC, then fetch -> PC=0; assert pc_reset_n=0 mid-cycle -> outputs cleared before the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and IF/ID pipeline register.
// A four-state controller (IDLE/RUN/STEP/HALT) decides when a fetch happens.
// Each fetch latches {PC, PC+PC_STEP, instruction, valid} and advances the PC.
// Per-cycle priority outside HALT: redirect > stall > fetch > idle.
module pc_fetch_unit #(
  parameter int                   ADDR_W       = 32,
  parameter int                   INSTR_W      = 32,
  parameter int                   PC_STEP      = 4,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD    = '1,
  parameter int                   CNT_W        = 16
) (
  input  logic               clk,
  input  logic               pc_reset_n,
  input  logic               pc_enable,
  input  logic               step_req,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_pc_out,
  output logic [ADDR_W-1:0]  if_pc_plus_out,
  output logic [INSTR_W-1:0] if_instr_out,
  output logic               if_valid_out,
  output logic [1:0]         state_out,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  // PC_STEP is a power of two, so clearing the low bits aligns a target.
  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP_A - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_t              state_q;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_next_seq;
  logic                is_halted;
  logic                take_redirect;
  logic                do_fetch;
  logic                fetched_halt;

  assign imem_addr   = pc_q;
  assign pc_next_seq = pc_q + STEP_A;  // wraps modulo 2^ADDR_W

  // Per-cycle decode; HALT masks every external control input.
  always_comb begin
    is_halted     = (state_q == HALT);
    take_redirect = !is_halted && redirect_valid;
    do_fetch      = ((state_q == RUN) || (state_q == STEP)) && !redirect_valid && !stall;
    fetched_halt  = do_fetch && (imem_rdata == HALT_WORD);
  end

  // State register.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) state_q <= IDLE;
    else             state_q <= state_nxt;
  end

  // Next-state logic; redirect or stall freezes the state in IDLE/RUN/STEP.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_nxt unassigned and infers a latch.
    state_nxt = state_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && !stall) begin
          if (pc_enable)     state_nxt = RUN;
          else if (step_req) state_nxt = STEP;
        end
      end
      RUN: begin
        if (do_fetch) begin
          if (fetched_halt)    state_nxt = HALT;
          else if (!pc_enable) state_nxt = IDLE;
        end
      end
      STEP: begin
        if (do_fetch) state_nxt = fetched_halt ? HALT : IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    state_out = state_q;
    halted    = (state_q == HALT);
  end

  // PC, IF/ID register and fetch counter.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!pc_reset_n) begin
      pc_q           <= RESET_VECTOR;
      if_pc_out      <= '0;
      if_pc_plus_out <= '0;
      if_instr_out   <= '0;
      if_valid_out   <= 1'b0;
      fetch_count    <= '0;
    end else if (is_halted) begin
      // Halt word stays visible but is only valid on the entry cycle.
      if_valid_out <= 1'b0;
    end else if (take_redirect) begin
      pc_q         <= redirect_addr & ALIGN_MASK;
      if_instr_out <= '0;
      if_valid_out <= 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (do_fetch) begin
      if_pc_out      <= pc_q;
      if_pc_plus_out <= pc_next_seq;
      if_instr_out   <= imem_rdata;
      if_valid_out   <= 1'b1;
      if (!fetched_halt)         pc_q        <= pc_next_seq;
      if (fetch_count != CNT_MAX) fetch_count <= fetch_count + CNT_W'(1);
    end else begin
      if_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. Each scenario task pushes the
// expected post-edge outputs onto a scoreboard queue as it drives a cycle,
// then pops and compares once the edge has produced the DUT's outputs.
module tb_pc_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;  // small so saturation is reachable quickly

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STEP = 2;
  localparam int S_HALT = 3;

  typedef struct packed {
    logic [1:0]  state;
    logic        halted;
    logic        valid;
    logic [15:0] count;
    logic [31:0] imem;
    logic [31:0] pc;
    logic [31:0] plus;
    logic [31:0] instr;
  } obs_t;

  typedef struct packed {
    logic        en;
    logic        step;
    logic        stl;
    logic        rv;
    logic [31:0] ra;
  } stim_t;

  logic               clk = 1'b0;
  logic               pc_reset_n;
  logic               pc_enable;
  logic               step_req;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0]  if_pc_out;
  logic [ADDR_W-1:0]  if_pc_plus_out;
  logic [INSTR_W-1:0] if_instr_out;
  logic               if_valid_out;
  logic [1:0]         state_out;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  logic [31:0] mem [256];
  obs_t        sb [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  pc_fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_STEP(4),
    .RESET_VECTOR('0), .HALT_WORD('1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .pc_reset_n(pc_reset_n), .pc_enable(pc_enable),
    .step_req(step_req), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_pc_out(if_pc_out),
    .if_pc_plus_out(if_pc_plus_out), .if_instr_out(if_instr_out),
    .if_valid_out(if_valid_out), .state_out(state_out), .halted(halted),
    .fetch_count(fetch_count)
  );

  function automatic obs_t mk(int s, int v, int pc, int plus, int instr, int cnt, int imem);
    obs_t e;
    e.state  = 2'(s);
    e.halted = (s == S_HALT);
    e.valid  = 1'(v);
    e.count  = 16'(cnt);
    e.imem   = 32'(imem);
    e.pc     = 32'(pc);
    e.plus   = 32'(plus);
    e.instr  = 32'(instr);
    return e;
  endfunction

  function automatic stim_t sv(int en, int step, int stl, int rv, int ra);
    stim_t s;
    s.en = 1'(en); s.step = 1'(step); s.stl = 1'(stl); s.rv = 1'(rv); s.ra = 32'(ra);
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state  = state_out;
    o.halted = halted;
    o.valid  = if_valid_out;
    o.count  = 16'(fetch_count);
    o.imem   = imem_addr;
    o.pc     = if_pc_out;
    o.plus   = if_pc_plus_out;
    o.instr  = if_instr_out;
    return o;
  endfunction

  task automatic drive(stim_t s);
    pc_enable      = s.en;
    step_req       = s.step;
    stall          = s.stl;
    redirect_valid = s.rv;
    redirect_addr  = s.ra;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    pc_reset_n = 1'b0;
    drive(sv(0, 0, 0, 0, 0));
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    repeat (2) @(negedge clk);
    pc_reset_n = 1'b1;
  endtask

  // Asynchronous reset at time zero, before any clock edge.
  task automatic test_reset();
    obs_t o, e;
    pc_reset_n = 1'b0;
    drive(sv(0, 0, 0, 0, 0));
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    #2;
    e = mk(S_IDLE, 0, 0, 0, 0, 0, 0);
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", o, e);
    end
  endtask

  task automatic test_run();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 0, 0, 0, 0, 0, 0));
    for (int k = 2; k <= 6; k++) begin
      st.push_back(sv(1, 0, 0, 0, 0));
      ex.push_back(mk(S_RUN, 1, 4*(k-2), 4*(k-2)+4, k-1, k-1, 4*(k-1)));
    end
    // Dropping pc_enable in RUN still fetches once, then returns to IDLE.
    st.push_back(sv(0, 0, 0, 0, 0)); ex.push_back(mk(S_IDLE, 1, 20, 24, 6, 6, 24));
    st.push_back(sv(0, 0, 0, 0, 0)); ex.push_back(mk(S_IDLE, 0, 20, 24, 6, 6, 24));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL run cycle %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 0, 0, 0, 0, 0, 0));
    for (int j = 0; j < 3; j++) begin
      st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 1, 4*j, 4*j+4, j+1, j+1, 4*j+4));
    end
    st.push_back(sv(1, 0, 1, 0, 0)); ex.push_back(mk(S_RUN, 1, 8, 12, 3, 3, 12));
    st.push_back(sv(1, 0, 1, 0, 0)); ex.push_back(mk(S_RUN, 1, 8, 12, 3, 3, 12));
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 1, 12, 16, 4, 4, 16));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall cycle %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    st.push_back(sv(1, 0, 0, 0, 0));     ex.push_back(mk(S_RUN, 0, 0, 0, 0, 0, 0));
    st.push_back(sv(1, 0, 0, 0, 0));     ex.push_back(mk(S_RUN, 1, 0, 4, 1, 1, 4));
    // Redirect wins over a simultaneous stall; target is aligned down.
    st.push_back(sv(1, 0, 1, 1, 'h103)); ex.push_back(mk(S_RUN, 0, 0, 4, 0, 1, 'h100));
    st.push_back(sv(1, 0, 0, 0, 0));     ex.push_back(mk(S_RUN, 1, 'h100, 'h104, 65, 2, 'h104));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL redirect cycle %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_step();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    st.push_back(sv(0, 0, 0, 1, 'h20)); ex.push_back(mk(S_IDLE, 0, 0, 0, 0, 0, 'h20));
    st.push_back(sv(0, 1, 0, 0, 0));    ex.push_back(mk(S_STEP, 0, 0, 0, 0, 0, 'h20));
    st.push_back(sv(0, 0, 0, 0, 0));    ex.push_back(mk(S_IDLE, 1, 'h20, 'h24, 9, 1, 'h24));
    st.push_back(sv(0, 0, 0, 0, 0));    ex.push_back(mk(S_IDLE, 0, 'h20, 'h24, 9, 1, 'h24));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL step cycle %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_halt();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    mem[3] = 32'hFFFF_FFFF;
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 0, 0, 0, 0, 0, 0));
    for (int j = 0; j < 3; j++) begin
      st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 1, 4*j, 4*j+4, j+1, j+1, 4*j+4));
    end
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_HALT, 1, 12, 16, -1, 4, 12));
    // Every control input is ignored once halted.
    st.push_back(sv(1, 1, 1, 1, 'h40)); ex.push_back(mk(S_HALT, 0, 12, 16, -1, 4, 12));
    st.push_back(sv(1, 1, 0, 1, 'h40)); ex.push_back(mk(S_HALT, 0, 12, 16, -1, 4, 12));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt cycle %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_wrap_reset();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    // Redirect in IDLE keeps IDLE even with pc_enable high.
    st.push_back(sv(1, 0, 0, 1, 'hFFFF_FFFC)); ex.push_back(mk(S_IDLE, 0, 0, 0, 0, 0, 'hFFFF_FFFC));
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 0, 0, 0, 0, 0, 'hFFFF_FFFC));
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 1, 'hFFFF_FFFC, 0, 256, 1, 0));
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 1, 0, 4, 1, 2, 4));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap cycle %0d: got %h expected %h", i, o, e);
      end
    end
    // Mid-cycle reset must clear everything before the next edge.
    #3 pc_reset_n = 1'b0;
    sb.push_back(mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", o, e);
    end
    @(negedge clk);
    pc_reset_n = 1'b1;
  endtask

  task automatic test_saturate();
    stim_t st[$]; obs_t ex[$]; obs_t o, e;
    apply_reset();
    st.push_back(sv(1, 0, 0, 0, 0)); ex.push_back(mk(S_RUN, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      st.push_back(sv(1, 0, 0, 0, 0));
      ex.push_back(mk(S_RUN, 1, 4*(k-1), 4*k, k, (k > 15) ? 15 : k, 4*k));
    end
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate cycle %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_step();
    test_halt();
    test_wrap_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
